trig_alu_sequencer: RTL and testbench

TRIG_ALU_SEQUENCER -- requirements
Module: trig_alu_sequencer

---
 rtl/trig_alu_sequencer.sv | 89 ++++++++
 tb/tb_trig_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_alu_sequencer.sv
// rtl/trig_alu_sequencer.sv - sequences the shared ALU through CORDIC-style trig iterations
// Optional busy-cycle counter enabled by defining TRIG_BUSY_CNT_EN.
module trig_alu_sequencer #(
  parameter int          ITERS    = 16,
  parameter logic [3:0]  ADD_CODE = 4'b0000,
  parameter logic [3:0]  SUB_CODE = 4'b0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_start,
  input  logic        flush,
  input  logic        trig_sign,
  input  logic [3:0]  pipe_alu_control,
  output logic [3:0]  alu_control_out,
  output logic        alu_grant_trig,
  output logic        trig_load,
  output logic        trig_step_en,
  output logic [4:0]  iter_idx,
  output logic        stall,
  output logic        trig_done,
  output logic [15:0] busy_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(ITERS - 1);

  state_t     state;
  logic [4:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_start) begin
            state <= LOAD;
            idx_q <= '0;
          end
        end
        LOAD: state <= ITER;
        ITER: begin
          // Index stops at the last iteration so DONE reports ITERS-1.
          if (idx_q == LAST_IDX) state <= DONE;
          else                   idx_q <= idx_q + 5'd1;
        end
        DONE: begin
          if (trig_start) begin
            state <= LOAD;
            idx_q <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign trig_load      = (state == LOAD);
  assign trig_step_en   = (state == ITER);
  assign trig_done      = (state == DONE);
  assign stall          = (state == LOAD) || (state == ITER);
  assign alu_grant_trig = stall;
  assign iter_idx       = idx_q;

  // Negative residual angle rotates the other way: add instead of subtract.
  assign alu_control_out = (state == ITER) ? (trig_sign ? ADD_CODE : SUB_CODE)
                                           : (stall ? SUB_CODE : pipe_alu_control);

`ifdef TRIG_BUSY_CNT_EN
  logic [15:0] busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          busy_q <= '0;
    else if (stall && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
  end

  assign busy_cycles = busy_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_trig_alu_sequencer.sv
// tb/tb_trig_alu_sequencer.sv - directed self-checking bench for trig_alu_sequencer
module tb_trig_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig_start;
  logic        flush;
  logic        trig_sign;
  logic [3:0]  pipe_alu_control;
  logic [3:0]  alu_control_out;
  logic        alu_grant_trig;
  logic        trig_load;
  logic        trig_step_en;
  logic [4:0]  iter_idx;
  logic        stall;
  logic        trig_done;
  logic [15:0] busy_cycles;

  int vec_cnt = 0;
  int err_cnt = 0;

  trig_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .trig_start(trig_start), .flush(flush),
    .trig_sign(trig_sign), .pipe_alu_control(pipe_alu_control),
    .alu_control_out(alu_control_out), .alu_grant_trig(alu_grant_trig),
    .trig_load(trig_load), .trig_step_en(trig_step_en), .iter_idx(iter_idx),
    .stall(stall), .trig_done(trig_done), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; trig_start = 1'b0; flush = 1'b0; trig_sign = 1'b0;
    pipe_alu_control = 4'b0110;
    @(negedge clk);
    vec_cnt++;
    if ({stall, trig_load, trig_step_en, trig_done, alu_grant_trig, iter_idx, busy_cycles} !== 26'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs got stall=%b load=%b step=%b done=%b grant=%b idx=%0d busy=%0d want all 0",
               stall, trig_load, trig_step_en, trig_done, alu_grant_trig, iter_idx, busy_cycles);
    end
    vec_cnt++;
    if (alu_control_out !== 4'b0110) begin
      err_cnt++; $display("FAIL reset_alu_pass got %b want 0110", alu_control_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({stall, trig_load, trig_done} !== 3'b000 || alu_control_out !== 4'b0110) begin
      err_cnt++; $display("FAIL idle_after_reset got stall=%b load=%b done=%b alu=%b want 0 0 0 0110",
                          stall, trig_load, trig_done, alu_control_out);
    end
  endtask

  task automatic test_single_op();
    int stall_cnt = 0;
    trig_start = 1'b1;
    @(negedge clk);
    trig_start = 1'b0;
    if (stall) stall_cnt++;
    vec_cnt++;
    if ({trig_load, stall, alu_grant_trig, trig_step_en, trig_done} !== 5'b11100 || iter_idx !== 5'd0) begin
      err_cnt++; $display("FAIL load_cycle got load=%b stall=%b grant=%b step=%b done=%b idx=%0d want 1 1 1 0 0 0",
                          trig_load, stall, alu_grant_trig, trig_step_en, trig_done, iter_idx);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      trig_sign  = (i % 2 == 1);
      trig_start = (i == 3);
      #1;
      vec_cnt++;
      if ({trig_step_en, stall, alu_grant_trig, trig_load, trig_done} !== 5'b11100 || iter_idx !== 5'(i)) begin
        err_cnt++; $display("FAIL iter_%0d got step=%b stall=%b grant=%b load=%b done=%b idx=%0d want 1 1 1 0 0 %0d",
                            i, trig_step_en, stall, alu_grant_trig, trig_load, trig_done, iter_idx, i);
      end
      vec_cnt++;
      if (alu_control_out !== ((i % 2 == 1) ? 4'b0000 : 4'b0001)) begin
        err_cnt++; $display("FAIL iter_alu_%0d got %b want %b", i, alu_control_out,
                            ((i % 2 == 1) ? 4'b0000 : 4'b0001));
      end
    end
    trig_start = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    vec_cnt++;
    if ({trig_done, stall, alu_grant_trig, trig_load, trig_step_en} !== 5'b10000 || iter_idx !== 5'd15
        || alu_control_out !== 4'b0110) begin
      err_cnt++; $display("FAIL done_cycle got done=%b stall=%b grant=%b load=%b step=%b idx=%0d alu=%b want 1 0 0 0 0 15 0110",
                          trig_done, stall, alu_grant_trig, trig_load, trig_step_en, iter_idx, alu_control_out);
    end
    @(negedge clk);
    vec_cnt++;
    if ({trig_done, stall, trig_load} !== 3'b000) begin
      err_cnt++; $display("FAIL idle_after_done got done=%b stall=%b load=%b want 0 0 0", trig_done, stall, trig_load);
    end
    vec_cnt++;
    if (stall_cnt !== 17) begin
      err_cnt++; $display("FAIL stall_length got %0d want 17", stall_cnt);
    end
  endtask

  task automatic test_busy();
    int done_seen = 0;
    trig_start = 1'b1;
    @(negedge clk);
    trig_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trig_done) done_seen++;
    end
    vec_cnt++;
    if (done_seen !== 1) begin
      err_cnt++; $display("FAIL busy_op_done got %0d pulses want 1", done_seen);
    end
    vec_cnt++;
`ifdef TRIG_BUSY_CNT_EN
    if (busy_cycles !== 16'd34) begin
      err_cnt++; $display("FAIL busy_cycles got %0d want 34", busy_cycles);
    end
`else
    if (busy_cycles !== 16'd0) begin
      err_cnt++; $display("FAIL busy_cycles got %0d want 0", busy_cycles);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int low_stall = 0;
    trig_start = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      @(negedge clk);
      if (trig_done) done_cyc.push_back(c);
      if (!stall) low_stall++;
      if (c == 54) trig_start = 1'b0;
    end
    vec_cnt++;
    if (done_cyc.size() !== 3) begin
      err_cnt++; $display("FAIL b2b_done_count got %0d want 3", done_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vec_cnt++;
        if (done_cyc[k] !== 18 * (k + 1)) begin
          err_cnt++; $display("FAIL b2b_done_cycle_%0d got %0d want %0d", k, done_cyc[k], 18 * (k + 1));
        end
      end
    end
    vec_cnt++;
    if (low_stall !== 3) begin
      err_cnt++; $display("FAIL b2b_stall_gaps got %0d want 3", low_stall);
    end
    @(negedge clk);
    vec_cnt++;
    if ({stall, trig_load, trig_done} !== 3'b000) begin
      err_cnt++; $display("FAIL b2b_idle got stall=%b load=%b done=%b want 0 0 0", stall, trig_load, trig_done);
    end
  endtask

  task automatic test_flush();
    bit found = 0;
    int done_seen = 0;
    flush = 1'b1; trig_start = 1'b1;
    @(negedge clk);
    flush = 1'b0; trig_start = 1'b0;
    vec_cnt++;
    if ({trig_load, stall} !== 2'b00) begin
      err_cnt++; $display("FAIL flush_priority got load=%b stall=%b want 0 0", trig_load, stall);
    end
    trig_start = 1'b1;
    @(negedge clk);
    trig_start = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (trig_step_en && iter_idx == 5'd7) found = 1;
      else @(negedge clk);
    end
    vec_cnt++;
    if (!found) begin
      err_cnt++; $display("FAIL flush_reach_idx7 got timeout want iter_idx=7");
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++;
    if ({stall, alu_grant_trig, trig_step_en, trig_done, trig_load} !== 5'b00000) begin
      err_cnt++; $display("FAIL flush_idle got stall=%b grant=%b step=%b done=%b load=%b want all 0",
                          stall, alu_grant_trig, trig_step_en, trig_done, trig_load);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trig_done) done_seen++;
    end
    vec_cnt++;
    if (done_seen !== 0) begin
      err_cnt++; $display("FAIL flush_no_done got %0d pulses want 0", done_seen);
    end
    trig_start = 1'b1;
    @(negedge clk);
    trig_start = 1'b0;
    vec_cnt++;
    if (trig_load !== 1'b1 || iter_idx !== 5'd0) begin
      err_cnt++; $display("FAIL restart_load got load=%b idx=%0d want 1 0", trig_load, iter_idx);
    end
    @(negedge clk);
    vec_cnt++;
    if (trig_step_en !== 1'b1 || iter_idx !== 5'd0) begin
      err_cnt++; $display("FAIL restart_iter0 got step=%b idx=%0d want 1 0", trig_step_en, iter_idx);
    end
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trig_done) done_seen++;
    end
    vec_cnt++;
    if (done_seen !== 1) begin
      err_cnt++; $display("FAIL restart_done got %0d pulses want 1", done_seen);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    int done_seen = 0;
    trig_start = 1'b1;
    @(negedge clk);
    trig_start = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (trig_step_en && iter_idx == 5'd5) found = 1;
      else @(negedge clk);
    end
    vec_cnt++;
    if (!found) begin
      err_cnt++; $display("FAIL rst_reach_idx5 got timeout want iter_idx=5");
    end
    pipe_alu_control = 4'b1010;
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({stall, trig_load, trig_step_en, trig_done, alu_grant_trig, iter_idx, busy_cycles} !== 26'd0
        || alu_control_out !== 4'b1010) begin
      err_cnt++; $display("FAIL async_reset got stall=%b load=%b step=%b done=%b grant=%b idx=%0d busy=%0d alu=%b want zeros alu=1010",
                          stall, trig_load, trig_step_en, trig_done, alu_grant_trig, iter_idx, busy_cycles, alu_control_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trig_done || stall) done_seen++;
    end
    vec_cnt++;
    if (done_seen !== 0) begin
      err_cnt++; $display("FAIL rst_abandon got %0d active cycles want 0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_busy();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
